flappy_bird_param_fetch: RTL and testbench
==========================================

FLAPPY_BIRD_PARAM_FETCH -- requirements
Module: flappy_bird_param_fetch

Interface
REQ-001 Parameter DATA_W, default 32: memory word width; the only supported value is 32.
REQ-002 Parameter NUM_PARAMS, default 3: parameter words read per frame, at addresses 0..NUM_PARAMS-1.
REQ-003 Parameter STATUS_ADDR, default 3: address of the hardware status mailbox word.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 frame_start  in  1  single-cycle frame strobe from the video timing block.
REQ-007 status_in  in  32  hardware game status (collision, score, flags), written back to memory.
REQ-008 mem_address  out  2  word address to the on-chip memory slave.
REQ-009 mem_chipselect  out  1  memory access enable.
REQ-010 mem_write  out  1  write strobe; 0 means read.
REQ-011 mem_byteenable  out  4  byte lanes; constant 4'hF.
REQ-012 mem_writedata  out  32  write data.
REQ-013 mem_clken  out  1  memory clock enable; constant 1.
REQ-014 mem_readdata  in  32  memory read data, valid one cycle after the address is presented.
REQ-015 param0, param1, param2  out  32 each  committed parameter words.
REQ-016 params_valid  out  1  one-cycle pulse when the param outputs update.
REQ-017 busy  out  1  high in every state other than IDLE.
REQ-018 frame_overrun  out  1  one-cycle pulse when frame_start arrives while busy.

Function
REQ-019 The FSM SHALL have states IDLE, RD0, RD1, RD2 and FIN, each lasting exactly one cycle except IDLE.
REQ-020 IDLE SHALL go to RD0 when frame_start=1 and SHALL otherwise hold.
REQ-021 The FSM SHALL step RD0->RD1->RD2->FIN->IDLE unconditionally.
REQ-022 RD0, RD1 and RD2 SHALL drive mem_chipselect=1, mem_write=0 and mem_address=0, 1 and 2 respectively.
REQ-023 mem_readdata SHALL be captured into shadow word k (k=0, 1, 2) in the cycle after RDk, i.e. in RD1, RD2 and FIN respectively.
REQ-024 FIN SHALL drive mem_address=STATUS_ADDR and mem_writedata=status_in.
REQ-025 FIN SHALL drive mem_chipselect=mem_write=dirty, where dirty = (status_in != last_written).
REQ-026 On a FIN write, last_written SHALL load status_in; at most one write SHALL occur per frame.
REQ-027 On the cycle after FIN, param0..param2 SHALL all load the shadow words together and params_valid SHALL pulse for that cycle.
REQ-028 Latency: frame_start sampled in cycle T SHALL give updated params and params_valid=1 in cycle T+5.
REQ-029 Outside RD0..FIN, mem_chipselect=0 and mem_write=0.
REQ-030 frame_start in any non-IDLE state SHALL be dropped and SHALL pulse frame_overrun in the following cycle.
REQ-031 frame_start in the IDLE cycle that carries params_valid SHALL be accepted, giving a minimum frame period of 5 cycles.
REQ-032 param outputs SHALL hold between commits; the outputs SHALL never expose a partially updated set.

Reset
REQ-033 reset SHALL force IDLE and clear param0..param2, the shadow words and last_written to 0.
REQ-034 reset SHALL drive params_valid, busy, frame_overrun, mem_chipselect, mem_write, mem_address and mem_writedata to 0.
REQ-035 Reset mid-fetch SHALL abort the fetch with no memory write and no params_valid pulse.
REQ-036 reset SHALL take priority over frame_start in the same cycle.

Structure
REQ-037 The state encoding, STATUS_ADDR and the word-index constants SHALL live in the shared package flappy_bird_control_pkg.
REQ-038 The block SHALL be a single module with no sub-module: FSM, shadow registers and dirty compare together.

Verification
REQ-039 Memory model with words {0x11,0x22,0x33,0x0}, status_in=0, frame_start at T -> reads of addresses 0,1,2 in T+1..T+3, no write, params = 0x11/0x22/0x33 with params_valid at T+5.
REQ-040 status_in=0xA5 then two frames -> write of 0xA5 to address 3 in FIN of frame 1 only; frame 2 FIN has chipselect=0.
REQ-041 frame_start at T and again at T+2 -> second strobe ignored, frame_overrun=1 at T+3, exactly one params_valid.
REQ-042 frame_start at T and T+5 -> two complete fetches, params_valid at T+5 and T+10.
REQ-043 reset asserted at T+3 of a fetch with status dirty -> no write, params stay 0, no params_valid, busy=0 at T+4.
REQ-044 Memory word 1 changed between frames -> param1 updates only at the params_valid of the next fetch and holds the old value before it.

Source files
------------

// File: rtl/flappy_bird_control_pkg.sv
// Shared definitions for the flappy-bird parameter fetch block.
// Holds the fetch FSM state encoding, the default address of the status
// mailbox word, the memory address width and the parameter word indices.
package flappy_bird_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  localparam int ADDR_W          = 2;
  localparam int PKG_STATUS_ADDR = 3;

  // Parameter word indices; each word sits at the address equal to its index.
  localparam int WORD0 = 0;
  localparam int WORD1 = 1;
  localparam int WORD2 = 2;

  function automatic logic [ADDR_W-1:0] word_addr(input int k);
    return ADDR_W'(k);
  endfunction

endpackage

// File: rtl/flappy_bird_param_fetch.sv
// Per-frame parameter fetch / status write-back for the flappy-bird core.
// On each frame_start strobe the block reads three parameter words from the
// on-chip memory (addresses 0..2), writes the hardware game status to the
// mailbox word only when it differs from the last value written, and then
// commits all three parameters to the outputs at once with params_valid.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   frame_start       one-cycle frame strobe; dropped (frame_overrun) if busy
//   status_in         game status to mirror into the mailbox word
//   mem_*             memory slave port (read data valid one cycle after address)
//   param0..param2    committed parameter words
//   params_valid      one-cycle pulse when param0..param2 update
//   busy              high while a fetch is in flight
//   frame_overrun     one-cycle pulse, the cycle after a dropped strobe
//
// Only DATA_W = 32 and NUM_PARAMS = 3 are supported.
module flappy_bird_param_fetch
  import flappy_bird_control_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_PARAMS  = 3,
  parameter int STATUS_ADDR = PKG_STATUS_ADDR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [DATA_W-1:0]     status_in,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic [DATA_W-1:0]     param0,
  output logic [DATA_W-1:0]     param1,
  output logic [DATA_W-1:0]     param2,
  output logic                  params_valid,
  output logic                  busy,
  output logic                  frame_overrun
);

  state_t state, state_next;

  logic [NUM_PARAMS-1:0][DATA_W-1:0] shadow, shadow_next, params;
  logic [DATA_W-1:0]                 last_written;
  logic                              dirty;

  assign dirty          = (status_in != last_written);
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;
  assign param0         = params[WORD0];
  assign param1         = params[WORD1];
  assign param2         = params[WORD2];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (frame_start) state_next = ST_RD0;
      ST_RD0:  state_next = ST_RD1;
      ST_RD1:  state_next = ST_RD2;
      ST_RD2:  state_next = ST_FIN;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Memory-port outputs. Gated by reset so an abort in FIN never leaks a
  // write, and the port reads as idle for the whole reset cycle.
  always_comb begin
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    busy           = 1'b0;
    if (!reset) begin
      busy = (state != ST_IDLE);
      case (state)
        ST_RD0: begin mem_chipselect = 1'b1; mem_address = word_addr(WORD0); end
        ST_RD1: begin mem_chipselect = 1'b1; mem_address = word_addr(WORD1); end
        ST_RD2: begin mem_chipselect = 1'b1; mem_address = word_addr(WORD2); end
        ST_FIN: begin
          // Write-back only when the status changed since the last write.
          mem_chipselect = dirty;
          mem_write      = dirty;
          mem_address    = ADDR_W'(STATUS_ADDR);
          mem_writedata  = status_in;
        end
        default: ;
      endcase
    end
  end

  // Read data lags the address by one cycle, so word k lands in the state
  // after RDk. shadow_next folds that cycle's word in, which lets FIN commit
  // word 2 straight from the bus together with the two earlier words.
  always_comb begin
    shadow_next = shadow;
    case (state)
      ST_RD1:  shadow_next[WORD0] = mem_readdata;
      ST_RD2:  shadow_next[WORD1] = mem_readdata;
      ST_FIN:  shadow_next[WORD2] = mem_readdata;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow        <= '0;
      params        <= '0;
      last_written  <= '0;
      params_valid  <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      shadow        <= shadow_next;
      params_valid  <= 1'b0;
      frame_overrun <= frame_start && (state != ST_IDLE);
      if (state == ST_FIN) begin
        params       <= shadow_next;
        params_valid <= 1'b1;
        if (dirty) last_written <= status_in;
      end
    end
  end

endmodule

// File: tb/tb_flappy_bird_param_fetch.sv
// Self-checking bench for flappy_bird_param_fetch. A small memory model sits
// on the slave port; expectations come from an event-time reference model
// (cycle of the last accepted strobe, pending snapshot of the memory words,
// last status written) and are compared every cycle.
module tb_flappy_bird_param_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic [31:0] status_in = '0;
  logic [1:0]  mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;
  logic [31:0] param0, param1, param2;
  logic        params_valid, busy, frame_overrun;

  always #5 clk = ~clk;

  flappy_bird_param_fetch dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .status_in(status_in),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .param0(param0), .param1(param1), .param2(param2),
    .params_valid(params_valid), .busy(busy), .frame_overrun(frame_overrun)
  );

  // Memory: words 0..2 set by the bench, word 3 is the status mailbox.
  logic [31:0] mem [0:3];
  logic [31:0] status_word = '0;
  logic [31:0] mem_rd;
  assign mem_readdata = mem_rd;

  always @(posedge clk) begin
    if (mem_chipselect && mem_write && mem_address == 2'd3) status_word <= mem_writedata;
    mem_rd <= (mem_address == 2'd3) ? status_word : mem[mem_address];
  end

  // Reference model state
  int          cyc = 0;
  int          acc_t = -100;   // cycle in which the last strobe was accepted
  int          valid_at = -1;  // cycle expected to carry params_valid
  int          ovr_at = -1;    // cycle expected to carry frame_overrun
  logic [31:0] exp_p [3];
  logic [31:0] pend [3];
  logic [31:0] last_w = '0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  function automatic bit in_fetch(input int c);
    return (c - acc_t) >= 1 && (c - acc_t) <= 4;
  endfunction

  task automatic check_all(input bit rst, input logic [31:0] st);
    int age;
    logic        e_cs, e_we;
    logic [1:0]  e_addr;
    logic [31:0] e_wd;
    age = cyc - acc_t;
    e_cs = 1'b0; e_we = 1'b0; e_addr = 2'd0; e_wd = '0;
    if (!rst) begin
      if (age >= 1 && age <= 3) begin
        e_cs = 1'b1; e_addr = 2'(age - 1);
      end else if (age == 4) begin
        e_cs = (st != last_w); e_we = (st != last_w); e_addr = 2'd3; e_wd = st;
      end
    end
    chk("busy",          {31'd0, busy},           {31'd0, !rst && in_fetch(cyc)});
    chk("chipselect",    {31'd0, mem_chipselect}, {31'd0, e_cs});
    chk("write",         {31'd0, mem_write},      {31'd0, e_we});
    chk("address",       {30'd0, mem_address},    {30'd0, e_addr});
    chk("writedata",     mem_writedata,           e_wd);
    chk("params_valid",  {31'd0, params_valid},   {31'd0, cyc == valid_at});
    chk("frame_overrun", {31'd0, frame_overrun},  {31'd0, cyc == ovr_at});
    chk("param0",        param0,                  exp_p[0]);
    chk("param1",        param1,                  exp_p[1]);
    chk("param2",        param2,                  exp_p[2]);
    chk("byteenable",    {28'd0, mem_byteenable}, 32'hF);
    chk("clken",         {31'd0, mem_clken},      32'd1);
  endtask

  // One clock cycle: drive inputs, check, advance the model.
  task automatic step(input bit fs, input bit rst, input logic [31:0] st, input bit en);
    int age;
    @(negedge clk);
    frame_start = fs; reset = rst; status_in = st;
    #1;
    if (en) check_all(rst, st);
    if (rst) begin
      acc_t = -100; valid_at = -1; ovr_at = -1; last_w = '0;
      for (int k = 0; k < 3; k++) exp_p[k] = '0;
    end else begin
      age = cyc - acc_t;
      if (age == 4) begin
        for (int k = 0; k < 3; k++) exp_p[k] = pend[k];
        last_w = st;
      end
      if (fs) begin
        if (in_fetch(cyc)) ovr_at = cyc + 1;
        else begin
          acc_t = cyc; valid_at = cyc + 5;
          for (int k = 0; k < 3; k++) pend[k] = mem[k];
        end
      end
    end
    cyc++;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n, input logic [31:0] st);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, st, 1'b1);
  endtask

  initial begin
    logic [31:0] st_cur;
    bit          fs, rst;
    for (int k = 0; k < 3; k++) begin exp_p[k] = '0; pend[k] = '0; end
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h0;

    // Reset; first cycle unchecked (registers not yet initialised).
    step(1'b0, 1'b1, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0, 1'b1);   // reset beats frame_start
    idle(2, 32'h0);

    // Basic fetch, clean status: no write, params 11/22/33 at T+5.
    step(1'b1, 1'b0, 32'h0, 1'b1);
    idle(6, 32'h0);

    // Dirty status written once, second frame sees it clean.
    step(1'b1, 1'b0, 32'hA5, 1'b1); idle(5, 32'hA5);
    step(1'b1, 1'b0, 32'hA5, 1'b1); idle(5, 32'hA5);

    // Strobe at T and T+2: second dropped with overrun.
    step(1'b1, 1'b0, 32'hA5, 1'b1); idle(1, 32'hA5);
    step(1'b1, 1'b0, 32'hA5, 1'b1); idle(5, 32'hA5);

    // Back-to-back at minimum period.
    mem[0] = 32'hDEAD0000; mem[2] = 32'h0000BEEF;
    step(1'b1, 1'b0, 32'hA5, 1'b1); idle(4, 32'hA5);
    step(1'b1, 1'b0, 32'hA5, 1'b1); idle(6, 32'hA5);

    // Word 1 changes between frames.
    mem[1] = 32'h12345678;
    step(1'b1, 1'b0, 32'hA5, 1'b1); idle(6, 32'hA5);

    // Reset in RD2 with dirty status: abort, no write, no params_valid.
    step(1'b1, 1'b0, 32'h5A, 1'b1); idle(2, 32'h5A);
    step(1'b0, 1'b1, 32'h5A, 1'b1);
    idle(6, 32'h5A);

    // Reset during FIN with dirty status.
    step(1'b1, 1'b0, 32'h77, 1'b1); idle(3, 32'h77);
    step(1'b0, 1'b1, 32'h77, 1'b1);
    idle(3, 32'h77);

    // Randomized traffic.
    st_cur = 32'h0;
    for (int i = 0; i < 600; i++) begin
      if (!in_fetch(cyc) && $urandom_range(0, 7) == 0)
        mem[$urandom_range(0, 2)] = $urandom;
      if ($urandom_range(0, 5) == 0)
        st_cur = ($urandom_range(0, 1) == 0) ? 32'hA5 : $urandom;
      fs  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 49) == 0);
      step(fs, rst, st_cur, 1'b1);
    end
    idle(6, st_cur);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
